// File: rtl/uart_pkg.sv
// Shared types and widths for the UART receive-side flow-control slice.
package uart_pkg;
    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned FERR_CNT_W  = 8;

    typedef enum logic {
        RTS_RUN  = 1'b0,
        RTS_HOLD = 1'b1
    } rts_state_t;
endpackage

// File: rtl/uart_rx_flow_ctrl_if.sv
// Receiver-to-consumer byte path: receiver strobe side plus valid/ready head port.
interface uart_rx_flow_ctrl_if;
    import uart_pkg::*;

    logic                   rx_valid;
    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_ferr;
    logic                   m_valid;
    logic [UART_DATA_W-1:0] m_data;
    logic                   m_ready;

    modport master (
        output rx_valid, rx_data, rx_ferr, m_ready,
        input  m_valid, m_data
    );

    modport slave (
        input  rx_valid, rx_data, rx_ferr, m_ready,
        output m_valid, m_data
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is mem[rd_ptr].
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
endmodule

// File: rtl/uart_rx_flow_ctrl.sv
// UART receive controller: byte FIFO, RTS hysteresis, framing/overflow statistics.
// Optional build macro UART_RX_FERR_DROP_EN: discard bytes flagged with a framing error.
module uart_rx_flow_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned HI_WATER = 12,
    parameter int unsigned LO_WATER = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_rx_flow_ctrl_if.slave      bus,
    output logic                    rts,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [FERR_CNT_W-1:0]   ferr_cnt,
    input  logic                    stat_clr
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          store_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [LW-1:0] level_next;
    rts_state_t    state_q;
    rts_state_t    state_d;

`ifdef UART_RX_FERR_DROP_EN
    assign store_req = bus.rx_valid & ~bus.rx_ferr;
`else
    assign store_req = bus.rx_valid;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop         = ~empty & bus.m_ready;
    assign push        = store_req & (~full | pop);
    assign bus.m_valid = ~empty;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.rx_data),
        .dout  (bus.m_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RTS_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RTS_RUN:  if (level_next >= LW'(HI_WATER)) state_d = RTS_HOLD;
            RTS_HOLD: if (level_next <= LW'(LO_WATER)) state_d = RTS_RUN;
            default:  state_d = RTS_RUN;
        endcase
    end

    assign rts = (state_q == RTS_RUN);

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            overflow <= 1'b0;
            ferr_cnt <= '0;
        end else begin
            if (store_req && full && !pop) begin
                overflow <= 1'b1;
            end
            if (bus.rx_valid && bus.rx_ferr && (ferr_cnt != '1)) begin
                ferr_cnt <= ferr_cnt + FERR_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_flow_ctrl.sv
// Bench for uart_rx_flow_ctrl: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_flow_ctrl;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned HI    = 12;
    localparam int unsigned LO    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       stat_clr;
    logic       rts;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] ferr_cnt;

    uart_rx_flow_ctrl_if bus ();

    uart_rx_flow_ctrl #(
        .DEPTH    (DEPTH),
        .HI_WATER (HI),
        .LO_WATER (LO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .rts      (rts),
        .level    (level),
        .overflow (overflow),
        .ferr_cnt (ferr_cnt),
        .stat_clr (stat_clr)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0] q[$];
    int unsigned ferr_m;
    bit          ovf_m;
    bit          rts_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour from the rules: queue of stored bytes, counters, RTS hysteresis.
    task automatic model(input bit rv, input logic [7:0] d, input bit fe,
                         input bit rdy, input bit clr, input bit r);
        bit store;
        if (r) begin
            q.delete();
            ferr_m = 0;
            ovf_m  = 1'b0;
            rts_m  = 1'b1;
            return;
        end
`ifdef UART_RX_FERR_DROP_EN
        store = rv && !fe;
`else
        store = rv;
`endif
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (store) begin
            if (q.size() < DEPTH) q.push_back(d);
            else ovf_m = 1'b1;
        end
        if (rv && fe && ferr_m < 255) ferr_m++;
        if (clr) begin
            ferr_m = 0;
            ovf_m  = 1'b0;
        end
        if (q.size() >= HI) rts_m = 1'b0;
        else if (q.size() <= LO) rts_m = 1'b1;
    endtask

    task automatic step(input bit rv, input logic [7:0] d, input bit fe,
                        input bit rdy, input bit clr, input bit r);
        bus.rx_valid = rv;
        bus.rx_data  = d;
        bus.rx_ferr  = fe;
        bus.m_ready  = rdy;
        stat_clr     = clr;
        rst          = r;
        @(posedge clk);
        model(rv, d, fe, rdy, clr, r);
        #1;
        check("m_valid", 32'(bus.m_valid), 32'(q.size() > 0));
        if (q.size() > 0) check("m_data", 32'(bus.m_data), 32'(q[0]));
        check("level", 32'(level), 32'(q.size()));
        check("rts", 32'(rts), 32'(rts_m));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("ferr_cnt", 32'(ferr_cnt), 32'(ferr_m));
    endtask

    initial begin
        logic [7:0] seq [3];
        seq[0] = 8'h55; seq[1] = 8'hA3; seq[2] = 8'h0F;

        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);

        // Three bytes held, then drained in order.
        for (int i = 0; i < 3; i++) step(1, seq[i], 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0);

        // Fill to high water, drain past low water.
        for (int i = 0; i < 12; i++) step(1, 8'(i + 1), 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)  step(0, 8'h00, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)  step(0, 8'h00, 0, 1, 0, 0);

        // Fill, overflow byte, clear, then full with simultaneous push/pop.
        for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0, 0);
        step(0, 8'h00, 0, 0, 1, 0);
        step(1, 8'h77, 0, 1, 0, 0);
        for (int i = 0; i < 17; i++) step(0, 8'h00, 0, 1, 0, 0);

        // Framing-error bytes, then clear racing with another error.
        step(1, 8'h10, 1, 0, 0, 0);
        step(1, 8'h20, 1, 0, 0, 0);
        step(1, 8'h30, 1, 0, 0, 0);
        step(1, 8'h40, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1, 0, 0);

        // Reset with buffered bytes and RTS held off, while a byte strobes in.
        for (int i = 0; i < 12; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)  step(0, 8'h00, 0, 1, 0, 0);
        step(1, 8'hDD, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 0);

        // Random traffic with varying push/pop pressure.
        for (int ph = 0; ph < 12; ph++) begin
            int unsigned prv  = $urandom_range(95, 10);
            int unsigned prdy = $urandom_range(95, 5);
            for (int c = 0; c < 250; c++) begin
                step($urandom_range(99) < prv, 8'($urandom), $urandom_range(99) < 20,
                     $urandom_range(99) < prdy, $urandom_range(99) < 2,
                     $urandom_range(299) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
